// File: rtl/pipeexe_mdu.sv
// Execute stage: single-cycle ALU/shift/JAL path plus an iterative MUL/DIV unit with HI/LO.
// Optional MDU_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU; divides stay iterative.
module pipeexe_mdu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned RN_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               evalid,
    input  logic [3:0]         ealuc,
    input  logic [WIDTH-1:0]   ea,
    input  logic [WIDTH-1:0]   eb,
    input  logic [WIDTH-1:0]   eimm,
    input  logic [WIDTH-1:0]   epc4,
    input  logic [RN_W-1:0]    ern0,
    input  logic               ealuimm,
    input  logic               eshift,
    input  logic               ejal,
    input  logic [2:0]         emdop,
    output logic [WIDTH-1:0]   ealu,
    output logic [RN_W-1:0]    ern,
    output logic               estall,
    output logic               ebusy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned HW    = WIDTH / 2;

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_qm;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;

    // ---------------- single-cycle ALU path ----------------
    logic [SHAMT_W-1:0] w_sa;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH-1:0]   w_alu;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_sa    = eimm[6+SHAMT_W-1:6];
    assign w_opa   = eshift ? {{(WIDTH-SHAMT_W){1'b0}}, w_sa} : ea;
    assign w_opb   = ealuimm ? eimm : eb;
    assign w_shamt = w_opa[SHAMT_W-1:0];

    always_comb begin
        w_alu = '0;
        casez (ealuc)
            4'b?000: w_alu = w_opa + w_opb;
            4'b?100: w_alu = w_opa - w_opb;
            4'b?001: w_alu = w_opa & w_opb;
            4'b?101: w_alu = w_opa | w_opb;
            4'b?010: w_alu = w_opa ^ w_opb;
            4'b?110: w_alu = {w_opb[HW-1:0], {HW{1'b0}}};
            4'b0011: w_alu = w_opb << w_shamt;
            4'b0111: w_alu = w_opb >> w_shamt;
            4'b1111: w_alu = WIDTH'($signed(w_opb) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    assign ern = ern0 | {RN_W{ejal}};

    // ---------------- MDU operand decode ----------------
    logic               w_is_mul_op;
    logic               w_is_div_op;
    logic               w_signed_op;
    logic               w_iter_op;
    logic               w_launch;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_is_mul_op = (emdop == MD_MULT) || (emdop == MD_MULTU);
    assign w_is_div_op = (emdop == MD_DIV)  || (emdop == MD_DIVU);
    assign w_signed_op = (emdop == MD_MULT) || (emdop == MD_DIV);
    assign w_abs_a     = (w_signed_op && ea[WIDTH-1]) ? -ea : ea;
    assign w_abs_b     = (w_signed_op && eb[WIDTH-1]) ? -eb : eb;

`ifdef MDU_FAST_MUL_EN
    logic               w_fast_mul;
    logic [DW-1:0]      w_ext_a;
    logic [DW-1:0]      w_ext_b;
    logic [DW-1:0]      w_fprod;

    assign w_iter_op  = w_is_div_op;
    assign w_fast_mul = (r_state == S_IDLE) && evalid && w_is_mul_op;
    // Low 2W bits of the product of extended operands give the signed or unsigned result.
    assign w_ext_a    = {{WIDTH{w_signed_op & ea[WIDTH-1]}}, ea};
    assign w_ext_b    = {{WIDTH{w_signed_op & eb[WIDTH-1]}}, eb};
    assign w_fprod    = w_ext_a * w_ext_b;
`else
    assign w_iter_op  = w_is_mul_op || w_is_div_op;
`endif

    assign w_launch = (r_state == S_IDLE) && evalid && w_iter_op;

    // ---------------- radix-2 step datapath ----------------
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH+1:0]   w_ddiff;
    logic               w_dfit;
    logic               w_unused_ddiff;

    assign w_msum         = {1'b0, r_acc} + (r_qm[0] ? {1'b0, r_m} : '0);
    assign w_dshift       = {r_acc, r_qm[WIDTH-1]};
    assign w_ddiff        = {1'b0, w_dshift} - {2'b00, r_m};
    assign w_dfit         = ~w_ddiff[WIDTH+1];
    assign w_unused_ddiff = w_ddiff[WIDTH];

    // ---------------- sign correction for the DONE write ----------------
    logic [DW-1:0]      w_prod;
    logic [DW-1:0]      w_prod_c;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod   = {r_acc, r_qm};
    assign w_prod_c = r_neg_res ? -w_prod : w_prod;
    assign w_quo    = r_dz ? '1 : (r_neg_res ? -r_qm : r_qm);
    assign w_rem    = r_neg_rem ? -r_acc : r_acc;
    assign w_res_hi = r_is_div ? w_rem : w_prod_c[DW-1:WIDTH];
    assign w_res_lo = r_is_div ? w_quo : w_prod_c[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        estall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next_state = S_BUSY;
                    estall       = 1'b1;
                end
            end
            S_BUSY: begin
                estall = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign ebusy = (r_state != S_IDLE);

    // Working registers, iteration counter and architectural HI/LO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_qm      <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_acc     <= '0;
                        r_qm      <= w_abs_a;
                        r_m       <= w_abs_b;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_is_div  <= w_is_div_op;
                        r_neg_res <= w_signed_op & (ea[WIDTH-1] ^ eb[WIDTH-1]);
                        r_neg_rem <= w_signed_op & ea[WIDTH-1];
                        r_dz      <= (eb == '0);
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (w_fast_mul) begin
                        r_hi <= w_fprod[DW-1:WIDTH];
                        r_lo <= w_fprod[WIDTH-1:0];
                    end
`endif
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_dfit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                        r_qm  <= {r_qm[WIDTH-2:0], w_dfit};
                    end else begin
                        r_acc <= w_msum[WIDTH:1];
                        r_qm  <= {w_msum[0], r_qm[WIDTH-1:1]};
                    end
                end
                S_DONE: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Result mux; in DONE an MFHI/MFLO sees the value being written this cycle.
    always_comb begin
        ealu = w_alu;
        if (ejal) begin
            ealu = epc4 + WIDTH'(4);
        end else if (emdop == MD_MFHI) begin
            ealu = (r_state == S_DONE) ? w_res_hi : r_hi;
        end else if (emdop == MD_MFLO) begin
            ealu = (r_state == S_DONE) ? w_res_lo : r_lo;
        end
    end

endmodule

// File: tb/tb_pipeexe_mdu.sv
// Directed self-checking bench for pipeexe_mdu (WIDTH=32).
module tb_pipeexe_mdu;

    logic        clock;
    logic        reset;
    logic        evalid;
    logic [3:0]  ealuc;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [31:0] epc4;
    logic [4:0]  ern0;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [2:0]  emdop;
    logic [31:0] ealu;
    logic [4:0]  ern;
    logic        estall;
    logic        ebusy;

    int checks = 0;
    int errors = 0;
    int n;
    logic [31:0] v;

`ifdef MDU_FAST_MUL_EN
    localparam int EXP_MUL_STALL = 0;
`else
    localparam int EXP_MUL_STALL = 33;
`endif
    localparam int EXP_DIV_STALL = 33;

    pipeexe_mdu #(.WIDTH(32), .SHAMT_W(5), .RN_W(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .evalid  (evalid),
        .ealuc   (ealuc),
        .ea      (ea),
        .eb      (eb),
        .eimm    (eimm),
        .epc4    (epc4),
        .ern0    (ern0),
        .ealuimm (ealuimm),
        .eshift  (eshift),
        .ejal    (ejal),
        .emdop   (emdop),
        .ealu    (ealu),
        .ern     (ern),
        .estall  (estall),
        .ebusy   (ebusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        evalid = 1'b0; ealuc = 4'd0; ea = '0; eb = '0; eimm = '0; epc4 = '0;
        ern0 = '0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0; emdop = 3'd0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bubble();
        evalid = 1'b1; emdop = op; ea = a; eb = b;
    endtask

    // Presents an MDU op and counts the cycles estall stays high; leaves a bubble after DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
        issue(op, a, b);
        #1;
        stalls = 0;
        while (estall === 1'b1 && stalls < 200) begin
            @(posedge clock); #1;
            stalls++;
        end
        @(posedge clock); #1;
        bubble();
    endtask

    task automatic read_mf(input logic [2:0] op, output logic [31:0] val);
        issue(op, 32'h0, 32'h0);
        #1;
        val = ealu;
        @(posedge clock); #1;
        bubble();
    endtask

    initial begin
        bubble();
        reset = 1'b1;
        #12;
        chk("rst_estall", {31'b0, estall}, 32'd0);
        chk("rst_ebusy",  {31'b0, ebusy},  32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // JAL path
        bubble(); evalid = 1'b1; ejal = 1'b1; epc4 = 32'h0040_0004; ern0 = 5'd0;
        #1;
        chk("jal_ealu", ealu, 32'h0040_0008);
        chk("jal_ern",  {27'b0, ern}, 32'd31);
        // SLL by sa
        bubble(); evalid = 1'b1; eshift = 1'b1; eimm = 32'h0000_00C0; eb = 32'd1;
        ealuc = 4'b0011; ern0 = 5'd5;
        #1;
        chk("sll_ealu",   ealu, 32'd8);
        chk("sll_estall", {31'b0, estall}, 32'd0);
        chk("sll_ern",    {27'b0, ern}, 32'd5);
        // ADD with immediate
        bubble(); evalid = 1'b1; ea = 32'd5; eimm = 32'hFFFF_FFFF; ealuimm = 1'b1; ealuc = 4'b0000;
        #1;
        chk("addi_ealu", ealu, 32'd4);
        @(posedge clock); #1;

        // MULTU all ones
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_stall", 32'(n), 32'(EXP_MUL_STALL));
        read_mf(3'd5, v); chk("multu_hi", v, 32'hFFFF_FFFE);
        read_mf(3'd6, v); chk("multu_lo", v, 32'h0000_0001);

        // Reset in the middle of a DIV
        issue(3'd3, 32'h1234_5678, 32'd3);
        repeat (5) begin @(posedge clock); #1; end
        chk("mid_ebusy", {31'b0, ebusy}, 32'd1);
        bubble();
        reset = 1'b1;
        #1;
        chk("arst_ebusy",  {31'b0, ebusy},  32'd0);
        chk("arst_estall", {31'b0, estall}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("post_ebusy", {31'b0, ebusy}, 32'd0);
        read_mf(3'd5, v); chk("rst_hi", v, 32'h0);
        read_mf(3'd6, v); chk("rst_lo", v, 32'h0);
        // New MULT after reset: 3 * -2 = -6
        run_op(3'd1, 32'd3, 32'hFFFF_FFFE, n);
        chk("mult_stall", 32'(n), 32'(EXP_MUL_STALL));
        read_mf(3'd5, v); chk("mult_hi", v, 32'hFFFF_FFFF);
        read_mf(3'd6, v); chk("mult_lo", v, 32'hFFFF_FFFA);

        // DIV / DIVU of -7 by 2
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_stall", 32'(n), 32'(EXP_DIV_STALL));
        read_mf(3'd6, v); chk("div_lo", v, 32'hFFFF_FFFD);
        read_mf(3'd5, v); chk("div_hi", v, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, n);
        read_mf(3'd6, v); chk("divu_lo", v, 32'h7FFF_FFFC);
        read_mf(3'd5, v); chk("divu_hi", v, 32'h0000_0001);

        // Divide by zero and signed overflow
        run_op(3'd3, 32'h1234_5678, 32'h0, n);
        chk("dz_stall", 32'(n), 32'(EXP_DIV_STALL));
        read_mf(3'd6, v); chk("dz_lo", v, 32'hFFFF_FFFF);
        read_mf(3'd5, v); chk("dz_hi", v, 32'h1234_5678);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        read_mf(3'd6, v); chk("ovf_lo", v, 32'h8000_0000);
        read_mf(3'd5, v); chk("ovf_hi", v, 32'h0);

        // MFLO presented one cycle after a DIV launch: 100 / 7 = 14 r 2
        issue(3'd3, 32'd100, 32'd7);
        #1;
        chk("lnch_estall", {31'b0, estall}, 32'd1);
        @(posedge clock); #1;
        issue(3'd6, 32'h0, 32'h0);
        #1;
        chk("il_ebusy", {31'b0, ebusy}, 32'd1);
        n = 0;
        while (estall === 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("il_stall", 32'(n), 32'd32);
        chk("il_done_lo", ealu, 32'd14);
        @(posedge clock); #1;
        chk("il_idle_lo",     ealu, 32'd14);
        chk("il_idle_estall", {31'b0, estall}, 32'd0);
        chk("il_idle_ebusy",  {31'b0, ebusy},  32'd0);
        bubble();
        read_mf(3'd5, v); chk("il_hi", v, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
